// File: rtl/seg7_serial_ctrl.sv
// Serial 7-segment chain driver: clears the chain, shifts one NBITS frame MSB-first
// on seg_clk, then latches the display enable. Every output is registered.
`timescale 1ns/1ps
module seg7_serial_ctrl #(
  parameter int NBITS = 64,
  parameter int DIV   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_do,
  output logic             seg_pen,
  output logic             seg_clr
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT_LO, SHIFT_HI, DONE} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             pen_q, pen_d;
  logic             clr_q, clr_d;
  logic             phase_end;

  assign phase_end = (div_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sreg_d  = data;
          div_d   = '0;
          bit_d   = '0;
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end) begin
          sreg_d  = sreg_q << 1;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BW'(NBITS - 1)) ? DONE : SHIFT_LO;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it;
    // sreg_d already holds the shifted word when SHIFT_LO is re-entered.
    busy_d = (state_d == CLEAR) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    done_d = (state_d == DONE);
    sclk_d = (state_d == SHIFT_HI);
    sdo_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? sreg_d[NBITS-1] : 1'b0;
    clr_d  = (state_d != CLEAR);
    pen_d  = pen_q || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      pen_q   <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      pen_q   <= pen_d;
      clr_q   <= clr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign seg_clk = sclk_q;
  assign seg_do  = sdo_q;
  assign seg_pen = pen_q;
  assign seg_clr = clr_q;
endmodule

// File: tb/tb_seg7_serial_ctrl.sv
// Bench for seg7_serial_ctrl: a small (8-bit, DIV=2) and a default (64-bit, DIV=8) instance
// traced cycle by cycle and compared against frame-level timing and bit-order rules.
`timescale 1ns/1ps
module tb_seg7_serial_ctrl;
  localparam int N8  = 8;
  localparam int D8  = 2;
  localparam int T8  = 1 + D8 * (1 + 2 * N8);
  localparam int D64 = 8;
  localparam int T64 = 1 + D64 * (1 + 2 * 64);

  logic        clk, rst;
  logic        start8, start64;
  logic [7:0]  data8;
  logic [63:0] data64;
  logic        busy8, done8, sclk8, sdo8, pen8, clr8;
  logic        busy64, done64, sclk64, sdo64, pen64, clr64;

  int checks = 0;
  int errors = 0;

  logic tr_busy [0:1100];
  logic tr_done [0:1100];
  logic tr_sclk [0:1100];
  logic tr_sdo  [0:1100];
  logic tr_pen  [0:1100];
  logic tr_clr  [0:1100];

  seg7_serial_ctrl #(.NBITS(N8), .DIV(D8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data(data8),
    .busy(busy8), .done(done8), .seg_clk(sclk8), .seg_do(sdo8),
    .seg_pen(pen8), .seg_clr(clr8)
  );

  seg7_serial_ctrl #(.NBITS(64), .DIV(D64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .data(data64),
    .busy(busy64), .done(done64), .seg_clk(sclk64), .seg_do(sdo64),
    .seg_pen(pen64), .seg_clr(clr64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic sample(input bit big, input int c);
    tr_busy[c] = big ? busy64 : busy8;
    tr_done[c] = big ? done64 : done8;
    tr_sclk[c] = big ? sclk64 : sclk8;
    tr_sdo[c]  = big ? sdo64  : sdo8;
    tr_pen[c]  = big ? pen64  : pen8;
    tr_clr[c]  = big ? clr64  : clr8;
  endtask

  // Caller sets start/data at a negedge; the following posedge is edge 0.
  // Trace index c holds the values seen during cycle c (sampled 1ns after edge c-1).
  task automatic capture(input bit big, input int ncyc, input bit hold, input int p1,
                         input int p2, input logic [63:0] d2, input int d2_from);
    logic st;
    sample(big, 0);
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      sample(big, c);
      st = (hold && c < ncyc) || c == p1 || c == p2;
      if (big) start64 = st; else start8 = st;
      if (c >= d2_from) begin
        if (big) data64 = d2; else data8 = d2[7:0];
      end
      if (c < ncyc) @(posedge clk);
    end
  endtask

  // Rebuilds the word the chain would have clocked in from the trace.
  function automatic void extract(input int a, input int b, output int n, output logic [63:0] w);
    n = 0;
    w = '0;
    for (int c = a; c <= b; c++) begin
      if (tr_sclk[c] === 1'b1 && tr_sclk[c-1] === 1'b0) begin
        n++;
        w = {w[62:0], tr_sdo[c]};
      end
    end
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b0; start8 = 1'b0; start64 = 1'b0; data8 = '0; data64 = '0;
    #3 rst = 1'b1;
    #1;
    obs = {busy8, done8, sclk8, sdo8, pen8, clr8};
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL reset8 busy/done/clk/do/pen/clr=%b required 000001", obs);
    end
    obs = {busy64, done64, sclk64, sdo64, pen64, clr64};
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL reset64 busy/done/clk/do/pen/clr=%b required 000001", obs);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int n;
    logic [63:0] w;
    logic [3:0] obs, exp;
    @(negedge clk); data8 = 8'hA5; start8 = 1'b1;
    capture(0, T8 + 2, 0, 0, 0, '0, 9999);
    for (int c = 1; c <= T8 + 2; c++) begin
      obs = {tr_busy[c], tr_done[c], tr_clr[c], tr_pen[c]};
      exp = {c < T8, c == T8, c > D8, c >= T8};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_frame cycle %0d busy/done/clr/pen=%b required %b", c, obs, exp);
      end
    end
    extract(1, T8 + 2, n, w);
    checks++;
    if (n != N8 || w[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_bits edges=%0d word=%h required edges=8 word=a5", n, w[7:0]);
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    logic [63:0] w;
    logic [1:0] obs, exp;
    @(negedge clk); data8 = 8'h00; start8 = 1'b1;
    capture(0, T8 + 1, 0, 5, 20, 64'hFF, 5);
    for (int c = 1; c <= T8 + 1; c++) begin
      obs = {tr_busy[c], tr_done[c]};
      exp = {c < T8, c == T8};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d busy/done=%b required %b", c, obs, exp);
      end
    end
    extract(1, T8 + 1, n, w);
    checks++;
    if (n != N8 || w[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL ignore_bits edges=%0d word=%h required edges=8 word=00", n, w[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] w;
    logic [2:0] obs, exp;
    @(negedge clk); data8 = 8'h81; start8 = 1'b1;
    capture(0, 2 * T8, 1, 0, 0, 64'h7E, 2);
    for (int c = 1; c <= 2 * T8; c++) begin
      obs = {tr_busy[c], tr_done[c], tr_clr[c]};
      exp = {c != T8 && c != 2 * T8, c == T8 || c == 2 * T8,
             !(c <= D8 || (c > T8 && c <= T8 + D8))};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d busy/done/clr=%b required %b", c, obs, exp);
      end
    end
    extract(1, 2 * T8, n, w);
    checks++;
    if (n != 2 * N8 || w[15:0] !== 16'h817E) begin
      errors++;
      $display("FAIL b2b_bits edges=%0d word=%h required edges=16 word=817e", n, w[15:0]);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [63:0] w;
    logic [5:0] obs;
    logic [1:0] o2, e2;
    @(negedge clk); data8 = 8'hFF; start8 = 1'b1;
    capture(0, 19, 0, 0, 0, '0, 9999);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    obs = {busy8, done8, sclk8, sdo8, pen8, clr8};
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL midframe_reset busy/done/clk/do/pen/clr=%b required 000001", obs);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, pen8} !== 3'b000) begin
        errors++;
        $display("FAIL after_reset cycle %0d busy/done/pen=%b required 000", c, {busy8, done8, pen8});
      end
    end
    @(negedge clk); data8 = 8'h3C; start8 = 1'b1;
    capture(0, T8 + 1, 0, 0, 0, '0, 9999);
    for (int c = 1; c <= T8 + 1; c++) begin
      o2 = {tr_done[c], tr_pen[c]};
      e2 = {c == T8, c >= T8};
      checks++;
      if (o2 !== e2) begin
        errors++;
        $display("FAIL post_reset_frame cycle %0d done/pen=%b required %b", c, o2, e2);
      end
    end
    extract(1, T8 + 1, n, w);
    checks++;
    if (n != N8 || w[7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_bits edges=%0d word=%h required edges=8 word=3c", n, w[7:0]);
    end
  endtask

  task automatic test_random();
    int n, p, bad_done, bad_glitch;
    logic [63:0] w;
    logic [7:0] d, d2;
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      d2 = 8'($urandom);
      p  = int'($urandom_range(1, T8 - 2));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      @(negedge clk); data8 = d; start8 = 1'b1;
      capture(0, T8 + 1, 0, p, 0, {56'b0, d2}, int'($urandom_range(1, 30)));
      extract(1, T8 + 1, n, w);
      checks++;
      if (n != N8 || w[7:0] !== d) begin
        errors++;
        $display("FAIL random_bits frame %0d edges=%0d word=%h required edges=8 word=%h", k, n, w[7:0], d);
      end
      bad_done = 0;
      bad_glitch = 0;
      for (int c = 1; c <= T8 + 1; c++) begin
        if (tr_done[c] !== (c == T8) || tr_busy[c] !== (c < T8)) bad_done++;
        if (tr_sdo[c] !== tr_sdo[c-1] && tr_sclk[c] !== 1'b0) bad_glitch++;
      end
      checks++;
      if (bad_done != 0) begin
        errors++;
        $display("FAIL random_timing frame %0d bad_cycles=%0d required 0", k, bad_done);
      end
      checks++;
      if (bad_glitch != 0) begin
        errors++;
        $display("FAIL random_do_while_high frame %0d events=%0d required 0", k, bad_glitch);
      end
    end
  endtask

  task automatic test_defaults();
    int n, ndone, last;
    logic [63:0] w;
    @(negedge clk); data64 = 64'h0123_4567_89AB_CDEF; start64 = 1'b1;
    capture(1, T64 + 1, 0, 0, 0, '0, 99999);
    extract(1, T64 + 1, n, w);
    checks++;
    if (n != 64 || w !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL defaults_bits edges=%0d word=%h required edges=64 word=0123456789abcdef", n, w);
    end
    ndone = 0;
    for (int c = 1; c <= T64 + 1; c++) if (tr_done[c] === 1'b1) ndone++;
    checks++;
    if (tr_done[T64] !== 1'b1 || ndone != 1) begin
      errors++;
      $display("FAIL defaults_done done@%0d=%b count=%0d required 1 and 1", T64, tr_done[T64], ndone);
    end
    last = -1;
    for (int c = 2; c <= T64 + 1; c++) begin
      if (tr_sclk[c] !== tr_sclk[c-1]) begin
        if (last > 0) begin
          checks++;
          if (c - last != D64) begin
            errors++;
            $display("FAIL defaults_phase at cycle %0d length=%0d required %0d", last, c - last, D64);
          end
        end
        if (tr_sclk[c] === 1'b1 || last > 0) last = c;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_defaults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
